pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage RV32 core (fetch, decode `de`, execute `exe`, access `acc`, writeback `wb`). It takes hazard and wait requests from the hazard/forwarding manager, the branch unit and the memory ports. It drives per-stage register enables, bubble/flush controls and the PC redirect select. It also keeps saturating stall/flush performance counters and a sticky data-memory timeout flag.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters
- MEM_TMO, 15, wait-cycle count in MEM_WAIT after which `mem_timeout` sets (1..2^CNT_W-1)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- load_use_stall  in  1  hazard manager: `de` consumer needs a load result still in `exe`
- branch_taken_exe  in  1  branch/JAL/JALR in `exe` resolved taken
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req_acc  in  1  instruction in `acc` is a load/store
- dmem_ready  in  1  data memory completes the `acc` access this cycle
- cnt_clr  in  1  clears both performance counters
- pc_en, de_en, exe_en, acc_en, wb_en  out  1 each  stage register load enables
- de_flush  out  1  fetch->`de` register loads NOP bubble
- exe_bubble  out  1  `de`->`exe` register loads NOP bubble
- pc_sel  out  1  1: PC loads branch target; 0: PC+4
- state  out  2  current FSM state (debug)
- stall_cycles  out  CNT_W  cycles with pc_en=0 while not in reset
- flush_count  out  CNT_W  number of redirects taken
- mem_timeout  out  1  sticky; data memory exceeded MEM_TMO wait cycles

## Operation
- FSM states are RUN, LOAD_STALL and MEM_WAIT. Control outputs are combinational from state and inputs; state, counters and flag are registered.
- RUN evaluates in priority order; the first match wins:
  1. dmem_req_acc && !dmem_ready: all five enables 0, no bubbles. Next state is MEM_WAIT and the wait counter clears to 0.
  2. branch_taken_exe: all enables 1, pc_sel=1, de_flush=1, exe_bubble=1. flush_count increments. State stays RUN.
  3. load_use_stall: pc_en=0, de_en=0, exe_bubble=1, exe/acc/wb enables 1. Next state is LOAD_STALL.
  4. !imem_ready: pc_en=0, de_flush=1, all other enables 1.
  5. Otherwise all enables 1 and all flush/select outputs 0.
- LOAD_STALL lasts exactly one cycle. It applies the RUN rules with load_use_stall masked to 0, so a stale request cannot double-stall. It returns to RUN, except when rule 1 fires, in which case it goes to MEM_WAIT.
- MEM_WAIT:
  - While !dmem_ready: all enables 0. The wait counter increments and saturates at MEM_TMO. When it reaches MEM_TMO, mem_timeout sets and holds until rst. State stays MEM_WAIT.
  - On the dmem_ready cycle: apply RUN rules 2–5, with rule 1 suppressed and load_use_stall honoured. The next state is as RUN would choose, which may be LOAD_STALL.
- A branch_taken_exe that arrives while frozen is held by the frozen `exe` register and redirects on the exit cycle.
- Counters:
  - Both counters saturate at 2^CNT_W-1.
  - cnt_clr zeroes them and wins over any same-cycle increment.
  - stall_cycles counts every cycle with pc_en=0 except during rst.

## Timing
- Reset (rst=1 at edge): state=RUN, counters=0, mem_timeout=0, wait counter=0.
- While rst is high, combinationally: all enables 0, de_flush=1, exe_bubble=1, pc_sel=0, so the pipeline registers fill with bubbles.
- Reset mid-MEM_WAIT or mid-LOAD_STALL aborts to RUN on the next edge.
- Load-use penalty: 1 bubble.
- Taken-branch penalty: 2 squashed instructions (the one in `de` and the one being fetched). The redirect takes effect the same cycle; the PC holds the target after the edge.
- Memory wait: the pipe is frozen for N cycles when dmem_ready arrives N cycles after the request, then resumes on that ready cycle.
- Simultaneous branch_taken_exe and load_use_stall: the branch wins, since the `de` consumer is squashed. No LOAD_STALL entry occurs.

## Structure
- Package pipe_ctrl_pkg holds:
  - state encodings: RUN=2'd0, LOAD_STALL=2'd1, MEM_WAIT=2'd2 (2'd3 is illegal and recovers to RUN)
  - NOP encoding 32'h00000013 for users of de_flush/exe_bubble
- Sub-module sat_counter (width parameter, inc, clr, synchronous rst). It is instantiated three times: stall_cycles, flush_count and the MEM_WAIT wait counter.

## Test plan
- Reset: rst high for 2 cycles with random inputs -> enables all 0, de_flush=exe_bubble=1. After release: state=0, counters=0, mem_timeout=0.
- Load-use: load_use_stall=1 for 2 cycles in RUN -> cycle 1: pc_en=de_en=0, exe_bubble=1; cycle 2 (LOAD_STALL, masked): all enables 1; stall_cycles=1.
- Branch plus hazard: branch_taken_exe=1 and load_use_stall=1 together -> pc_sel=1, de_flush=exe_bubble=1, all enables 1, flush_count=1, state stays RUN.
- Memory wait: dmem_req_acc=1 with dmem_ready low for 3 cycles, then high -> 3 cycles of enables 0 plus the RUN cycle, then all enables 1; stall_cycles=4.
- Timeout: MEM_TMO=15, dmem_ready low for 20 cycles -> mem_timeout rises after the 15th wait cycle and stays 1 after ready returns, until rst.
- Saturation/clear: CNT_W=4, 20 imem_ready=0 cycles -> stall_cycles=15; cnt_clr with a stall in the same cycle -> 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RV32 pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  // Bubble instruction (addi x0,x0,0) loaded by de_flush / exe_bubble users.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic pc_en;
    logic de_en;
    logic exe_en;
    logic acc_en;
    logic wb_en;
    logic de_flush;
    logic exe_bubble;
    logic pc_sel;
  } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with clear; clear and reset win over increment.
module sat_counter #(
  parameter int unsigned W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables, bubbles, PC redirect,
// stall/flush performance counters and data-memory timeout flag.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MEM_TMO = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             branch_taken_exe,
  input  logic             imem_ready,
  input  logic             dmem_req_acc,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             de_en,
  output logic             exe_en,
  output logic             acc_en,
  output logic             wb_en,
  output logic             de_flush,
  output logic             exe_bubble,
  output logic             pc_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  state_e           state_q;
  state_e           state_d;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             wait_frozen;
  logic             mem_stall;
  logic             luse_eff;

  // Rule qualifiers shared by next-state and output logic.
  assign in_wait     = (state_q == MEM_WAIT);
  assign wait_frozen = in_wait && !dmem_ready;
  assign mem_stall   = !in_wait && dmem_req_acc && !dmem_ready;
  assign luse_eff    = load_use_stall && (state_q != LOAD_STALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; the encoding 2'd3 falls through to RUN.
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN, LOAD_STALL, MEM_WAIT: begin
        if (wait_frozen || mem_stall) begin
          state_d = MEM_WAIT;
        end else if (!branch_taken_exe && luse_eff) begin
          state_d = LOAD_STALL;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stage controls in rule-priority order.
  always_comb begin
    ctrl = '{pc_en: 1'b1, de_en: 1'b1, exe_en: 1'b1, acc_en: 1'b1, wb_en: 1'b1,
             de_flush: 1'b0, exe_bubble: 1'b0, pc_sel: 1'b0};
    if (rst) begin
      ctrl = '{pc_en: 1'b0, de_en: 1'b0, exe_en: 1'b0, acc_en: 1'b0, wb_en: 1'b0,
               de_flush: 1'b1, exe_bubble: 1'b1, pc_sel: 1'b0};
    end else if (wait_frozen || mem_stall) begin
      ctrl.pc_en  = 1'b0;
      ctrl.de_en  = 1'b0;
      ctrl.exe_en = 1'b0;
      ctrl.acc_en = 1'b0;
      ctrl.wb_en  = 1'b0;
    end else if (branch_taken_exe) begin
      ctrl.pc_sel     = 1'b1;
      ctrl.de_flush   = 1'b1;
      ctrl.exe_bubble = 1'b1;
    end else if (luse_eff) begin
      ctrl.pc_en      = 1'b0;
      ctrl.de_en      = 1'b0;
      ctrl.exe_bubble = 1'b1;
    end else if (!imem_ready) begin
      ctrl.pc_en    = 1'b0;
      ctrl.de_flush = 1'b1;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign de_en      = ctrl.de_en;
  assign exe_en     = ctrl.exe_en;
  assign acc_en     = ctrl.acc_en;
  assign wb_en      = ctrl.wb_en;
  assign de_flush   = ctrl.de_flush;
  assign exe_bubble = ctrl.exe_bubble;
  assign pc_sel     = ctrl.pc_sel;
  assign state      = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (!ctrl.pc_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (ctrl.pc_sel),
    .count (flush_count)
  );

  sat_counter #(.W(CNT_W), .MAX(CNT_W'(MEM_TMO))) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (mem_stall),
    .inc   (wait_frozen),
    .count (wait_cnt)
  );

  // Sticky: set on the wait cycle that brings the count to MEM_TMO.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (wait_frozen && (wait_cnt >= CNT_W'(MEM_TMO - 1))) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a cycle-level rule model.
module tb_pipe_ctrl;

  localparam int unsigned CW  = 4;
  localparam int unsigned TMO = 15;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst, load_use_stall, branch_taken_exe, imem_ready;
  logic          dmem_req_acc, dmem_ready, cnt_clr;
  logic          pc_en, de_en, exe_en, acc_en, wb_en, de_flush, exe_bubble, pc_sel;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles, flush_count;
  logic          mem_timeout;

  pipe_ctrl #(.CNT_W(CW), .MEM_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .load_use_stall(load_use_stall),
    .branch_taken_exe(branch_taken_exe), .imem_ready(imem_ready),
    .dmem_req_acc(dmem_req_acc), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_en(pc_en), .de_en(de_en), .exe_en(exe_en), .acc_en(acc_en), .wb_en(wb_en),
    .de_flush(de_flush), .exe_bubble(exe_bubble), .pc_sel(pc_sel), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: mode 0=running, 1=one-cycle load stall, 2=waiting on data memory.
  int m_mode  = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_tmo   = 1'b0;
  bit m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check model against DUT, advance the model.
  task automatic step(input bit r, input bit lu, input bit br, input bit ir,
                      input bit dq, input bit dr, input bit cc);
    int rule;
    logic [7:0] exp_ctrl;
    rst = r; load_use_stall = lu; branch_taken_exe = br; imem_ready = ir;
    dmem_req_acc = dq; dmem_ready = dr; cnt_clr = cc;
    #1;
    if (r)                              rule = 0;
    else if (m_mode == 2 && !dr)        rule = 1;
    else if (m_mode != 2 && dq && !dr)  rule = 1;
    else if (br)                        rule = 2;
    else if (lu && m_mode != 1)         rule = 3;
    else if (!ir)                       rule = 4;
    else                                rule = 5;
    // {pc,de,exe,acc,wb,de_flush,exe_bubble,pc_sel}
    case (rule)
      0:       exp_ctrl = 8'b00000110;
      1:       exp_ctrl = 8'b00000000;
      2:       exp_ctrl = 8'b11111111;
      3:       exp_ctrl = 8'b00111010;
      4:       exp_ctrl = 8'b01111100;
      default: exp_ctrl = 8'b11111000;
    endcase
    chk("ctrl", 32'({pc_en, de_en, exe_en, acc_en, wb_en, de_flush, exe_bubble, pc_sel}),
        32'(exp_ctrl));
    if (m_valid) begin
      chk("state", 32'(state), 32'(m_mode));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      chk("flush_count", 32'(flush_count), 32'(m_flush));
      chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
    end
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_tmo = 1'b0; m_valid = 1'b1;
    end else begin
      if (rule == 1 && m_mode == 2) begin
        if (m_wait + 1 >= int'(TMO)) m_tmo = 1'b1;
        m_wait = (m_wait + 1 > int'(TMO)) ? int'(TMO) : m_wait + 1;
      end else if (rule == 1) begin
        m_wait = 0;
      end
      if (cc) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (!exp_ctrl[7] && m_stall < CMAX) m_stall++;
        if (exp_ctrl[0] && m_flush < CMAX) m_flush++;
      end
      m_mode = (rule == 1) ? 2 : (rule == 3) ? 1 : 0;
    end
    #1;
  endtask

  task automatic idle(input bit cc);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, cc);
  endtask

  initial begin
    rst = 1'b1; load_use_stall = 1'b0; branch_taken_exe = 1'b0; imem_ready = 1'b1;
    dmem_req_acc = 1'b0; dmem_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge clk); #1;

    // Reset with random inputs.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_tmo", 32'(mem_timeout), 32'd0);

    // Load-use: one bubble, stale request masked.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lu_state", 32'(state), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
    chk("lu_back_run", 32'(state), 32'd0);

    // Branch wins over a simultaneous load-use.
    idle(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("br_flush_cnt", 32'(flush_count), 32'd1);
    chk("br_state", 32'(state), 32'd0);

    // Memory wait: request cycle plus 3 frozen cycles, then resume.
    idle(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("mw_stall_cnt", 32'(stall_cycles), 32'd4);
    chk("mw_state", 32'(state), 32'd0);
    idle(1'b0);

    // Saturation then clear racing a stall.
    idle(1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sat_stall", 32'(stall_cycles), 32'd15);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_stall", 32'(stall_cycles), 32'd0);

    // Timeout: 20 wait cycles with MEM_TMO=15.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 14) chk("tmo_before", 32'(mem_timeout), 32'd0);
      if (i == 15) chk("tmo_at", 32'(mem_timeout), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk("tmo_sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a memory wait.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_mw_state", 32'(state), 32'd0);
    chk("rst_mw_tmo", 32'(mem_timeout), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 60) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 40) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
